// File: rtl/ceespu_irq_ctrl.sv
// ceespu_irq_ctrl: latched, masked, fixed-priority interrupt controller with req/ack/done handshake
// Define CEESPU_IRQ_EDGE_EN to pend sources on rising edges instead of on level.
module ceespu_irq_ctrl #(
   parameter int                 NUM_IRQ    = 8,
   parameter logic [31:0]        VEC_BASE   = 32'h0000_0100,
   parameter int                 VEC_STRIDE = 16,
   parameter logic [NUM_IRQ-1:0] RESET_MASK = {{(NUM_IRQ-1){1'b0}}, 1'b1}
) (
   input  logic                       I_clk,
   input  logic                       I_rst_n,
   input  logic [NUM_IRQ-1:0]         I_src,
   input  logic                       I_mask_we,
   input  logic [NUM_IRQ-1:0]         I_mask_data,
   input  logic                       I_clr_we,
   input  logic [NUM_IRQ-1:0]         I_clr_data,
   input  logic                       I_irq_ack,
   input  logic                       I_irq_done,
   output logic                       O_irq,
   output logic [$clog2(NUM_IRQ)-1:0] O_irq_id,
   output logic [31:0]                O_irq_addr,
   output logic [NUM_IRQ-1:0]         O_pending,
   output logic [NUM_IRQ-1:0]         O_mask
);
   localparam int IW = $clog2(NUM_IRQ);
   localparam int SH = $clog2(VEC_STRIDE);
   localparam logic [NUM_IRQ-1:0] ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t             state_q, state_d;
   logic [NUM_IRQ-1:0] det, clr, elig;
   logic [IW-1:0]      win, id_d;
   logic               irq_d;
   logic [31:0]        addr_d;

`ifdef CEESPU_IRQ_EDGE_EN
   logic [NUM_IRQ-1:0] prev;
   always_ff @(posedge I_clk or negedge I_rst_n)
      if (!I_rst_n) prev <= '0;
      else prev <= I_src;
   assign det = I_src & ~prev;
`else
   assign det = I_src;
`endif

   // only the acknowledged ID is retired; a same-edge set still wins below
   assign clr  = (I_clr_we ? I_clr_data : '0) |
                 ((state_q == REQ && I_irq_ack) ? ONE << O_irq_id : '0);
   assign elig = O_pending & O_mask;

   always_comb begin
      win = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (elig[i]) win = IW'(i);
   end

   always_comb begin
      state_d = state_q;
      irq_d   = O_irq;
      id_d    = O_irq_id;
      addr_d  = O_irq_addr;
      case (state_q)
         IDLE: if (|elig) begin
            state_d = REQ;
            irq_d   = 1'b1;
            id_d    = win;
            addr_d  = VEC_BASE + (32'(win) << SH);
         end
         REQ: if (I_irq_ack) begin
            state_d = SERVICE;
            irq_d   = 1'b0;
         end
         SERVICE: if (I_irq_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge I_clk or negedge I_rst_n)
      if (!I_rst_n) begin
         state_q    <= IDLE;
         O_irq      <= 1'b0;
         O_irq_id   <= '0;
         O_irq_addr <= VEC_BASE;
         O_pending  <= '0;
         O_mask     <= RESET_MASK;
      end else begin
         state_q    <= state_d;
         O_irq      <= irq_d;
         O_irq_id   <= id_d;
         O_irq_addr <= addr_d;
         O_pending  <= (O_pending & ~clr) | det;
         if (I_mask_we) O_mask <= I_mask_data;
      end
endmodule

// File: tb/tb_ceespu_irq_ctrl.sv
// tb_ceespu_irq_ctrl: directed and random checks of ceespu_irq_ctrl against a cycle reference model
module tb_ceespu_irq_ctrl;
   localparam int          N  = 8;
   localparam logic [31:0] VB = 32'h0000_0100;
   localparam int          VS = 16;
`ifdef CEESPU_IRQ_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic         clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0] src = '0, mask_data = '0, clr_data = '0;
   logic         mask_we = 1'b0, clr_we = 1'b0, ack = 1'b0, done = 1'b0;
   logic         irq;
   logic [2:0]   irq_id;
   logic [31:0]  irq_addr;
   logic [N-1:0] pending, mask;

   int n_cmp = 0, n_err = 0;
   // reference model: phase 0 = idle, 1 = requesting, 2 = in handler
   logic [N-1:0] m_pend, m_mask, m_prev;
   int           m_ph, m_id;
   bit           m_irq, last_irq;
   int           d_req = 0;

   ceespu_irq_ctrl dut (
      .I_clk(clk), .I_rst_n(rst_n), .I_src(src),
      .I_mask_we(mask_we), .I_mask_data(mask_data),
      .I_clr_we(clr_we), .I_clr_data(clr_data),
      .I_irq_ack(ack), .I_irq_done(done),
      .O_irq(irq), .O_irq_id(irq_id), .O_irq_addr(irq_addr),
      .O_pending(pending), .O_mask(mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++)
         if (v[i]) return i;
      return 0;
   endfunction

   task automatic m_reset();
      m_pend = '0; m_mask = 8'h01; m_prev = '0;
      m_ph = 0; m_irq = 1'b0; m_id = 0; last_irq = 1'b0;
   endtask

   task automatic step();
      logic [N-1:0] det, clr, elig;
      det  = EDGE ? (src & ~m_prev) : src;
      clr  = clr_we ? clr_data : '0;
      if (m_ph == 1 && ack) clr[m_id] = 1'b1;
      elig = m_pend & m_mask;
      if (m_ph == 0 && elig != 0) begin
         m_ph = 1; m_irq = 1'b1; m_id = lowest(elig);
      end else if (m_ph == 1 && ack) begin
         m_ph = 2; m_irq = 1'b0;
      end else if (m_ph == 2 && done)
         m_ph = 0;
      m_pend = (m_pend & ~clr) | det;
      if (mask_we) m_mask = mask_data;
      m_prev = src;
      @(posedge clk);
      #1;
      mask_we = 1'b0; clr_we = 1'b0; ack = 1'b0; done = 1'b0;
      if (irq && !last_irq) d_req++;
      last_irq = irq;
      chk("irq", 32'(irq), 32'(m_irq));
      chk("irq_id", 32'(irq_id), 32'(m_id));
      chk("irq_addr", irq_addr, VB + 32'(m_id * VS));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("mask", 32'(mask), 32'(m_mask));
   endtask

   initial begin
      int cnt;
      m_reset();
      #12;
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_addr", irq_addr, 32'h100);
      chk("rst_pend", 32'(pending), 32'd0);
      chk("rst_mask", 32'(mask), 32'h01);
      rst_n = 1'b1;

      // timer pulse
      repeat (9) step();
      src = 8'h01; step(); src = '0;
      chk("t0_pend", 32'(pending[0]), 32'd1);
      chk("t0_irq_early", 32'(irq), 32'd0);
      step();
      chk("t0_irq", 32'(irq), 32'd1);
      chk("t0_addr", irq_addr, 32'h100);
      ack = 1'b1; step();
      chk("t0_ack_drop", 32'(irq), 32'd0);
      done = 1'b1; step(); step();

      // priority between 5 and 2
      mask_we = 1'b1; mask_data = 8'hFF; step();
      src = 8'h24; step(); src = '0; step();
      chk("pri_id2", 32'(irq_id), 32'd2);
      chk("pri_addr2", irq_addr, 32'h120);
      ack = 1'b1; step(); done = 1'b1; step(); step();
      chk("pri_id5", 32'(irq_id), 32'd5);
      chk("pri_addr5", irq_addr, 32'h150);
      ack = 1'b1; step(); done = 1'b1; step();

      // masked source latches but waits for unmask
      mask_we = 1'b1; mask_data = 8'h01; step();
      src = 8'h08; step(); src = '0;
      chk("msk_pend3", 32'(pending[3]), 32'd1);
      step(); step();
      chk("msk_noirq", 32'(irq), 32'd0);
      mask_we = 1'b1; mask_data = 8'h09; step();
      chk("msk_wait", 32'(irq), 32'd0);
      step();
      chk("msk_irq", 32'(irq), 32'd1);
      chk("msk_id3", 32'(irq_id), 32'd3);
      ack = 1'b1; step(); done = 1'b1; step();

      // new pulse on the same edge as the ack of that ID
      src = 8'h01; step(); src = '0; step();
      src = 8'h01; ack = 1'b1; step(); src = '0;
      chk("sw_pend0", 32'(pending[0]), 32'd1);
      done = 1'b1; step(); step();
      chk("sw_reirq", 32'(irq), 32'd1);
      chk("sw_id0", 32'(irq_id), 32'd0);
      ack = 1'b1; step(); done = 1'b1; step();

      // held level on source 1
      mask_we = 1'b1; mask_data = 8'hFF; step(); step();
      cnt = d_req;
      src = 8'h02;
      for (int i = 0; i < 20; i++) begin
         ack = m_irq; done = (m_ph == 2); step();
      end
      src = '0;
      for (int i = 0; i < 8; i++) begin
         ack = m_irq; done = (m_ph == 2); step();
      end
      cnt = d_req - cnt;
      if (EDGE) chk("hold_once", 32'(cnt), 32'd1);
      else      chk("hold_repend", 32'(cnt > 1), 32'd1);

      // random traffic
      for (int i = 0; i < 500; i++) begin
         src       = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
         mask_we   = ($urandom_range(0, 15) == 0);
         mask_data = 8'($urandom);
         clr_we    = ($urandom_range(0, 15) == 0);
         clr_data  = 8'($urandom);
         ack       = m_irq ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
         done      = ($urandom_range(0, 2) == 0);
         step();
      end

      // reset during REQ
      src = 8'h10; mask_we = 1'b1; mask_data = 8'hFF; step();
      for (int i = 0; i < 10 && m_ph != 1; i++) begin
         done = 1'b1; step();
      end
      chk("pre_rst_irq", 32'(irq), 32'd1);
      #2 rst_n = 1'b0; src = '0;
      #1 m_reset();
      chk("mid_rst_irq", 32'(irq), 32'd0);
      chk("mid_rst_pend", 32'(pending), 32'd0);
      chk("mid_rst_mask", 32'(mask), 32'h01);
      chk("mid_rst_addr", irq_addr, VB);
      #3 rst_n = 1'b1;
      repeat (3) step();
      src = 8'h01; step(); src = '0; step();
      chk("post_rst_irq", 32'(irq), 32'd1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ceespu_irq_ctrl.md
# ceespu_irq_ctrl

Interrupt controller between the Ceespu interrupt sources (the millisecond timer pulse on source 0, plus peripheral requests) and the CPU core. It latches single-cycle or level requests into a pending register, applies a software-writable enable mask and fixed priority, and presents one interrupt at a time to the core. The handshake is request, then acknowledge, then service-done. The core gets an interrupt ID and a vector address so it can jump straight to the handler.

## Interface
- NUM_IRQ, 8, number of interrupt sources (2..16); source 0 is the timer pulse
- VEC_BASE, 32'h0000_0100, vector address of source 0
- VEC_STRIDE, 16, byte distance between consecutive vectors (power of two)
- RESET_MASK, 1, enable mask value after reset (timer enabled)

- I_clk  input  1  clock; all state updates on rising edge
- I_rst_n  input  1  asynchronous active-low reset
- I_src  input  NUM_IRQ  raw interrupt requests; bit 0 driven by the timer pulse
- I_mask_we  input  1  write enable for mask register
- I_mask_data  input  NUM_IRQ  new mask value
- I_clr_we  input  1  software pending-clear strobe
- I_clr_data  input  NUM_IRQ  bits to clear in the pending register (write-1-to-clear)
- I_irq_ack  input  1  core accepts the presented interrupt
- I_irq_done  input  1  core returned from the handler
- O_irq  output  1  interrupt request to the core
- O_irq_id  output  $clog2(NUM_IRQ)  ID of the presented interrupt
- O_irq_addr  output  32  handler vector address, VEC_BASE + O_irq_id*VEC_STRIDE
- O_pending  output  NUM_IRQ  pending register, for software readout
- O_mask  output  NUM_IRQ  current mask register

## Operation
- Pending register
  - Bit i is set on any edge where source i is detected (see Configuration).
  - Bit i is cleared by acknowledge of ID i, or by I_clr_we with I_clr_data[i]=1.
  - A set and a clear on the same edge: set wins and the bit stays 1.
- Masked sources still latch into pending. They do not request until unmasked.
- Eligible vector = pending & mask. The lowest eligible index has the highest priority.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if eligible != 0, go to REQ. Register O_irq=1, O_irq_id = priority winner, O_irq_addr.
  - REQ: O_irq held high with a stable ID and address. If I_irq_ack=1, clear the pending bit for O_irq_id, set O_irq=0, go to SERVICE.
    - A mask or clear write during REQ does not retract or change the presented request.
  - SERVICE: no new request is presented (no nesting). If I_irq_done=1, go to IDLE.
- I_irq_ack outside REQ and I_irq_done outside SERVICE are ignored.
- Arithmetic: O_irq_addr = VEC_BASE + (O_irq_id << log2(VEC_STRIDE)), modulo 2^32.

## Timing
- Reset values (asynchronous, immediate):
  - O_irq=0, O_irq_id=0, O_irq_addr=VEC_BASE, O_pending=0, O_mask=RESET_MASK
  - FSM=IDLE, edge-detect history=0
- Latency from a source high in cycle N:
  - pending visible in cycle N+1
  - O_irq high in cycle N+2, if the FSM is in IDLE and the source is the winner
- An ack sampled at edge E drops O_irq in cycle E+1.
- The earliest next O_irq after done sampled at edge D is cycle D+2 (IDLE for one cycle).
- A mask write takes effect in eligibility one cycle after the write edge.
- Reset asserted mid-handshake returns to IDLE and drops O_irq immediately. The core must treat this as a cancelled interrupt.

## Configuration
- CEESPU_IRQ_EDGE_EN
  - Defined: each source passes through a per-bit rising-edge detector (register the previous value, set on src & ~prev). A held-high level sets pending only once.
  - Undefined: any cycle with I_src[i]=1 sets pending. A held level re-pends immediately after ack. The timer's single-cycle pulse behaves identically in both modes.

## Test plan
- After reset, drive a one-cycle pulse on I_src[0] in cycle 10 -> O_pending[0]=1 in cycle 11; O_irq=1, O_irq_id=0, O_irq_addr=32'h100 in cycle 12.
- Raise I_src[5] and I_src[2] in the same cycle with mask 8'hFF -> ID 2 is presented first (addr 32'h120). After ack and done, ID 5 is presented (addr 32'h150).
- Mask=8'h01, pulse I_src[3] -> O_pending[3]=1 and O_irq stays 0. Write mask 8'h09 -> O_irq with ID 3 two cycles after the write edge.
- Pulse I_src[0] on the same edge that acks ID 0 -> O_pending[0] stays 1, and a second ID 0 request follows done.
- Hold I_src[1] high for 20 cycles -> with CEESPU_IRQ_EDGE_EN, exactly one request. Without it, the source re-pends and is re-presented after each done.
- Drive I_rst_n low while in REQ -> O_irq, O_pending and the FSM reset in the same cycle. Mask returns to 8'h01.
